// File: rtl/fixed_pkg.sv
// fixed_pkg -- shared definitions for the sign-magnitude fixed-point blocks.
//   Q, N     : format constants (Q fractional bits, N-bit sign-magnitude word)
//   G        : default guard bits for wide internal accumulators
//   MAX_MAG  : largest representable magnitude, 2^(N-1)-1
//   sm2tc    : N-bit sign-magnitude -> N-bit two's complement (-0 -> 0)
//   tc2sm    : N-bit two's complement -> N-bit sign-magnitude (0 -> +0)
//   accum_state_t : fixed_accum FSM states
package fixed_pkg;

  localparam int Q = 15;
  localparam int N = 32;
  localparam int G = 8;

  localparam logic [N-1:0] MAX_MAG = {1'b0, {(N-1){1'b1}}};

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } accum_state_t;

  // Negative zero falls out naturally: negating a zero magnitude yields 0.
  function automatic logic [N-1:0] sm2tc(input logic [N-1:0] sm);
    logic [N-1:0] mag;
    mag = {1'b0, sm[N-2:0]};
    return sm[N-1] ? -mag : mag;
  endfunction

  // The one two's-complement value with no sign-magnitude twin, -2^(N-1),
  // saturates to -MAX_MAG.
  function automatic logic [N-1:0] tc2sm(input logic [N-1:0] tc);
    logic [N-1:0] mag;
    mag = tc[N-1] ? -tc : tc;
    if (mag[N-1]) return {1'b1, {(N-1){1'b1}}};
    return {tc[N-1], mag[N-2:0]};
  endfunction

endpackage

// File: rtl/fixed_sm2tc.sv
// fixed_sm2tc -- combinational sign-magnitude to two's-complement converter.
//   sm : IN_W-bit sign-magnitude input (bit IN_W-1 is the sign)
//   tc : OUT_W-bit two's-complement output, sign-extended; -0 maps to 0
// OUT_W must be >= IN_W.
module fixed_sm2tc #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 40
) (
  input  logic [IN_W-1:0]  sm,
  output logic [OUT_W-1:0] tc
);

  logic [OUT_W-1:0] mag;

  assign mag = OUT_W'(sm[IN_W-2:0]);
  // Negating a zero magnitude gives zero, so -0 needs no special case.
  assign tc  = sm[IN_W-1] ? -mag : mag;

endmodule

// File: rtl/fixed_accum.sv
// fixed_accum -- saturating sign-magnitude frame accumulator (MAC tail).
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : N-bit sign-magnitude product beat
//   in_ovr     : multiplier overflow flag for this beat (sticky per frame)
//   in_last    : final beat of the frame
//   in_valid / in_ready   : input handshake; in_ready is high only in ST_ACC
//   out_result : saturated frame sum, sign-magnitude, registered
//   out_ovr    : sticky frame overflow, registered
//   out_valid / out_ready : output handshake; result held until accepted
module fixed_accum
  import fixed_pkg::*;
#(
  parameter int G_BITS = fixed_pkg::G
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_ovr,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_result,
  output logic         out_ovr,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int W = N + G_BITS;

  // Internal clamp range is symmetric: +-(2^(W-1)-1).
  localparam logic signed [W:0] ACC_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] ACC_MIN = -ACC_MAX;

  accum_state_t state, state_next;

  logic [W-1:0]    acc;
  logic            sticky;
  logic [W-1:0]    beat;
  logic signed [W:0] sum_wide;
  logic            clamp_hi, clamp_lo, clamp;
  logic [W-1:0]    sat;
  logic [W-1:0]    sum_abs;
  logic            mag_ovf;
  logic [N-1:0]    res_sm;
  logic            accept;

  fixed_sm2tc #(.IN_W(N), .OUT_W(W)) u_sm2tc (
    .sm (in_data),
    .tc (beat)
  );

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  // One extra bit so the raw sum can never wrap before the clamp test.
  assign sum_wide = $signed({acc[W-1], acc}) + $signed({beat[W-1], beat});
  assign clamp_hi = (sum_wide > ACC_MAX);
  assign clamp_lo = (sum_wide < ACC_MIN);
  assign clamp    = clamp_hi | clamp_lo;
  assign sat      = clamp_hi ? ACC_MAX[W-1:0] :
                    clamp_lo ? ACC_MIN[W-1:0] : sum_wide[W-1:0];

  // Output saturation: anything beyond MAX_MAG becomes {sign, all ones}.
  // In-range sums fit an N-bit two's-complement word, so the shared
  // converter handles them (and emits zero as +0).
  assign sum_abs = sat[W-1] ? -sat : sat;
  assign mag_ovf = (sum_abs > {{G_BITS{1'b0}}, MAX_MAG});
  assign res_sm  = mag_ovf ? {sat[W-1], {(N-1){1'b1}}} : tc2sm(sat[N-1:0]);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_ACC:  if (accept && in_last) state_next = ST_DONE;
      ST_DONE: if (out_ready)         state_next = ST_ACC;
      default:                        state_next = ST_ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sticky     <= 1'b0;
      out_result <= '0;
      out_ovr    <= 1'b0;
    end else if (accept) begin
      acc    <= sat;
      sticky <= sticky | clamp | in_ovr;
      if (in_last) begin
        out_result <= res_sm;
        out_ovr    <= sticky | clamp | in_ovr | mag_ovf;
      end
    end else if (out_valid && out_ready) begin
      // Result consumed: next frame starts from a clean slate.
      acc    <= '0;
      sticky <= 1'b0;
    end
  end

endmodule

// File: doc/fixed_accum.md
Name: fixed_accum

Overview:
- Sequential sign-magnitude fixed-point accumulator that sits directly downstream of the fixed-point multiplier.
- Sums a frame of products (dot-product / MAC tail) and returns one saturated sum per frame.
- Operand format matches the multiplier: bit N-1 is the sign, bits N-2:0 are the magnitude, and Q of those bits are fractional.
- Valid/ready handshake on both sides; carries the multiplier's overflow flag through as a sticky per-frame flag.

Parameters:
- Q, 15, fractional bits (informational; the arithmetic is format-agnostic).
- N, 32, word width, sign-magnitude.
- G, 8, guard bits in the internal two's-complement accumulator.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N  product word, sign-magnitude.
- in_ovr  input  1  overflow flag from the multiplier for this beat.
- in_last  input  1  marks the final beat of the frame.
- in_valid  input  1  input beat valid.
- in_ready  output  1  accumulator can accept a beat.
- out_result  output  N  saturated frame sum, sign-magnitude.
- out_ovr  output  1  sticky overflow for the frame.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset: acc=0, sticky=0, state=ACC. Output values at reset: out_result=0, out_ovr=0, out_valid=0, in_ready=1.
- Reset is asynchronous. Asserting it mid-frame or mid-hold discards the partial sum and any pending result.
- State ACC (in_ready=1):
  - A beat is accepted when in_valid && in_ready.
  - The beat converts to two's complement at N+G bits: +mag if sign=0, -mag if sign=1.
  - Negative zero (sign=1, mag=0) is treated as 0.
  - The add saturates: acc clamps to the range ±(2^(N+G-1)-1). A clamp sets sticky.
  - in_ovr on an accepted beat sets sticky.
  - An accepted beat with in_last=1 transitions to DONE.
- Output registration, on the same edge as the in_last beat:
  - out_result is registered from acc+beat.
  - If |acc+beat| > 2^(N-1)-1: out_result = {sign, all ones}, and out_ovr = 1.
  - Otherwise out_result = {sign, |sum|[N-2:0]}.
  - A zero sum is always emitted as +0 (0x0).
  - out_ovr = sticky | clamp | in_ovr, evaluated on that beat.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- State DONE:
  - out_valid=1 and in_ready=0.
  - out_result and out_ovr are held stable until out_valid && out_ready.
  - On that handshake: out_valid=0, acc=0, sticky=0, return to ACC. in_ready=1 from the next cycle; there is no same-cycle bypass.
- in_valid while in DONE is ignored; the beat is not consumed.
- A single-beat frame (first beat has in_last=1) is legal.
- Frame length is unbounded; internal saturation covers runaway sums.
- in_data and in_last are sampled only on the handshake.
- Neither registered output is combinationally dependent on any input.
- in_ready depends on state only.

Decomposition:
- Shared package fixed_pkg holds:
  - the format constants Q and N;
  - sign-magnitude to two's-complement and two's-complement to sign-magnitude conversion functions;
  - MAX_MAG = 2^(N-1)-1.
- One natural sub-module: fixed_sm2tc.
  - Combinational sign-magnitude to two's-complement converter, width-parameterised, with negative zero mapped to 0.
  - Reusable by the future subtractor/divider.
- The FSM, saturating adder and output saturation stay in fixed_accum.

Test Plan:
- Frame 0x00008000 (+1.0), 0x00004000 (+0.5), 0x80002000 (-0.25, last) -> out_result=0x0000A000, out_ovr=0, out_valid one cycle after the last beat.
- Single beat 0x80000000 (-0), last -> out_result=0x00000000, out_ovr=0.
- Overflow by sum: 0x7FFFFFFF twice -> out_result=0x7FFFFFFF, out_ovr=1. Same with 0xFFFFFFFF twice -> out_result=0xFFFFFFFF, out_ovr=1.
- Input overflow flag: frame 0x00008000 with in_ovr=1, then 0x00008000 last with in_ovr=0 -> out_result=0x00010000, out_ovr=1. The next frame 0x00004000 last -> out_ovr=0 (sticky cleared).
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 -> out_result stable, in_ready=0, no beat consumed. Release -> next frame starts from acc=0.
- Reset mid-frame: accept 0x00008000, pulse rst_n low -> outputs return to their reset values. A following frame 0x00004000 last -> out_result=0x00004000.
